// File: rtl/mul_div_seq_if.sv
// mul_div_seq_if: EX-stage request/response bundle for the multi-cycle
// multiply/divide sequencer.
//   master (EX stage): drives start, op, opA, opB, flush; observes busy,
//                      done, result_lo, result_hi, div_by_zero.
//   slave  (sequencer): the mirror image.
interface mul_div_seq_if;
  logic        start;
  logic        op;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        flush;
  logic        busy;
  logic        done;
  logic [15:0] result_lo;
  logic [15:0] result_hi;
  logic        div_by_zero;

  modport master (
    output start, op, opA, opB, flush,
    input  busy, done, result_lo, result_hi, div_by_zero
  );

  modport slave (
    input  start, op, opA, opB, flush,
    output busy, done, result_lo, result_hi, div_by_zero
  );
endinterface

// File: rtl/mul_div_seq.sv
// mul_div_seq: unsigned 16x16 shift-add multiply / 16/16 restoring divide,
// one bit per cycle on a 17-bit adder. Stalls EX via busy, returns a
// registered result with a one-cycle done pulse.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - mul_div_seq_if.slave (start/op/opA/opB/flush in,
//           busy/done/result_lo/result_hi/div_by_zero out)
// Build option: define MUL_DIV_SEQ_DIV_EN to compile in the divider; without
// it a DIV request completes in one cycle with a zero result.
//
// state  | meaning
// IDLE   | waiting for start, outputs hold last result
// RUN    | 16 iteration steps, counter 0..15
// DONE   | result registers valid, done pulse
module mul_div_seq (
  input  logic         clk,
  input  logic         rst_n,
  mul_div_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q;
  logic [15:0] w_hi_q, w_lo_q, d_q;
  logic [15:0] res_lo_q, res_hi_q;
  logic        accept;
  logic        imm_done;
  logic [16:0] mul_sum;
  logic [15:0] step_hi, step_lo;

`ifdef MUL_DIV_SEQ_DIV_EN
  logic        op_q;
  logic        dbz_q;
  logic [15:0] sh_hi;
  logic [16:0] sub;
`endif

  assign accept = (state_q == S_IDLE) && bus.start && !bus.flush;

`ifdef MUL_DIV_SEQ_DIV_EN
  assign imm_done = bus.op && (bus.opB == 16'd0);
`else
  assign imm_done = bus.op;
`endif

  // One iteration of the selected algorithm on the working registers.
  always_comb begin
    mul_sum = {1'b0, w_hi_q} + (w_lo_q[0] ? {1'b0, d_q} : 17'd0);
    step_hi = mul_sum[16:1];
    step_lo = {mul_sum[0], w_lo_q[15:1]};
`ifdef MUL_DIV_SEQ_DIV_EN
    // The partial remainder after k steps is below 2^k, so w_hi_q[15] is
    // always 0 before a shift and 16 bits hold the shifted remainder.
    sh_hi = {w_hi_q[14:0], w_lo_q[15]};
    sub   = {1'b0, sh_hi} - {1'b0, d_q};
    if (op_q) begin
      if (!sub[16]) begin
        step_hi = sub[15:0];
        step_lo = {w_lo_q[14:0], 1'b1};
      end else begin
        step_hi = sh_hi;
        step_lo = {w_lo_q[14:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = imm_done ? S_DONE : S_RUN;
      S_RUN:   if (cnt_q == 4'd15) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      w_hi_q <= '0;
      w_lo_q <= '0;
      d_q    <= '0;
`ifdef MUL_DIV_SEQ_DIV_EN
      op_q   <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q  <= '0;
      w_hi_q <= '0;
      w_lo_q <= bus.opA;
      d_q    <= bus.opB;
`ifdef MUL_DIV_SEQ_DIV_EN
      op_q   <= bus.op;
`endif
    end else if (state_q == S_RUN) begin
      cnt_q  <= cnt_q + 4'd1;
      w_hi_q <= step_hi;
      w_lo_q <= step_lo;
    end
  end

  // Result registers load only on entry to DONE. The final step's output is
  // captured directly so the 16th iteration needs no extra cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_lo_q <= '0;
      res_hi_q <= '0;
`ifdef MUL_DIV_SEQ_DIV_EN
      dbz_q    <= 1'b0;
`endif
    end else if (accept && imm_done) begin
`ifdef MUL_DIV_SEQ_DIV_EN
      res_lo_q <= 16'hFFFF;
      res_hi_q <= bus.opA;
      dbz_q    <= 1'b1;
`else
      res_lo_q <= '0;
      res_hi_q <= '0;
`endif
    end else if ((state_q == S_RUN) && (state_d == S_DONE)) begin
      res_lo_q <= step_lo;
      res_hi_q <= step_hi;
`ifdef MUL_DIV_SEQ_DIV_EN
      dbz_q    <= 1'b0;
`endif
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.result_lo = res_lo_q;
  assign bus.result_hi = res_hi_q;
`ifdef MUL_DIV_SEQ_DIV_EN
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq: table-driven vectors for mul_div_seq plus hand-written
// sequences for flush, ignored start, flush in DONE and mid-run reset.
// Expectations follow the build: DIV results only when MUL_DIV_SEQ_DIV_EN
// is defined, otherwise a DIV request returns zeros after one cycle.
module tb_mul_div_seq;

`ifdef MUL_DIV_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dbz;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  mul_div_seq_if bus();

  mul_div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk_mul(input string n, input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] hi, input logic [15:0] lo);
    vec_t v;
    v.name = n; v.op = 1'b0; v.a = a; v.b = b;
    v.lo = lo; v.hi = hi; v.dbz = 1'b0; v.lat = 17;
    return v;
  endfunction

  function automatic vec_t mk_div(input string n, input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] q, input logic [15:0] r, input logic dbz);
    vec_t v;
    v.name = n; v.op = 1'b1; v.a = a; v.b = b;
    if (DIV_EN) begin
      v.lo = q; v.hi = r; v.dbz = dbz; v.lat = dbz ? 1 : 17;
    end else begin
      v.lo = 16'h0; v.hi = 16'h0; v.dbz = 1'b0; v.lat = 1;
    end
    return v;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // DONE cycle (or after the time budget). Operands are scrambled after the
  // accepting edge to show they were latched.
  task automatic run_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                        output int lat);
    bus.start = 1'b1; bus.op = o; bus.opA = a; bus.opB = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.opA = 16'hA5A5; bus.opB = 16'h5A5A;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 40);
  endtask

  vec_t tv[11];
  int   lat;

  initial begin
    tv[0]  = mk_mul("mul_3x5",       16'h0003, 16'h0005, 16'h0000, 16'h000F);
    tv[1]  = mk_mul("mul_1234x10",   16'h1234, 16'h0010, 16'h0001, 16'h2340);
    tv[2]  = mk_mul("mul_ffffxffff", 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);
    tv[3]  = mk_mul("mul_0xffff",    16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
    tv[4]  = mk_mul("mul_8000x2",    16'h8000, 16'h0002, 16'h0001, 16'h0000);
    tv[5]  = mk_div("div_100_7",     16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0);
    tv[6]  = mk_div("div_ffff_1",    16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0);
    tv[7]  = mk_div("div_1234_0",    16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1);
    tv[8]  = mk_div("div_ffff_ff",   16'hFFFF, 16'h00FF, 16'h0101, 16'h0000, 1'b0);
    tv[9]  = mk_div("div_1000_1000", 16'd1000, 16'd1000, 16'h0001, 16'h0000, 1'b0);
    tv[10] = mk_mul("mul_101x101",   16'h0101, 16'h0101, 16'h0001, 16'h0201);

    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 1'b0; bus.opA = '0; bus.opB = '0; bus.flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_lo",   bus.result_lo, 0);
    check("reset_hi",   bus.result_hi, 0);
    check("reset_dbz",  bus.div_by_zero, 0);

    for (int i = 0; i < 11; i++) begin
      run_op(tv[i].op, tv[i].a, tv[i].b, lat);
      check({tv[i].name, "_lat"},  lat, tv[i].lat);
      check({tv[i].name, "_busy"}, bus.busy, 1);
      check({tv[i].name, "_lo"},   bus.result_lo, tv[i].lo);
      check({tv[i].name, "_hi"},   bus.result_hi, tv[i].hi);
      check({tv[i].name, "_dbz"},  bus.div_by_zero, tv[i].dbz);
      @(negedge clk);
      check({tv[i].name, "_idle"}, {bus.busy, bus.done}, 0);
    end

    // Flush in cycle 8 of a MUL: no done, prior result (0x0001/0x0201) kept.
    bus.start = 1'b1; bus.op = 1'b0; bus.opA = 16'h0007; bus.opB = 16'h0009;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    begin
      int seen = 0;
      for (int c = 0; c < 12; c++) begin
        if (bus.done) seen++;
        @(negedge clk);
      end
      check("flush_no_done", seen, 0);
    end
    check("flush_keep_lo", bus.result_lo, 16'h0201);
    check("flush_keep_hi", bus.result_hi, 16'h0001);

    // Start and flush together in IDLE: flush wins.
    bus.start = 1'b1; bus.flush = 1'b1; bus.op = 1'b0; bus.opA = 16'h0002; bus.opB = 16'h0002;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    check("start_flush_idle", bus.busy, 0);

    // Start pulsed in cycle 5 of a run is ignored and not queued.
    bus.start = 1'b1; bus.op = 1'b0; bus.opA = 16'h0011; bus.opB = 16'h0003;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 5) begin
        bus.start = 1'b1; bus.opA = 16'h00FF; bus.opB = 16'h00FF;
      end else begin
        bus.start = 1'b0;
      end
    end while (!bus.done && lat < 40);
    check("ign_start_lat", lat, 17);
    check("ign_start_lo", bus.result_lo, 16'h0033);
    @(negedge clk);
    check("ign_start_noq1", bus.busy, 0);
    @(negedge clk);
    check("ign_start_noq2", bus.busy, 0);

    // Flush during DONE: done still high with fresh outputs, then IDLE.
    run_op(1'b0, 16'h0100, 16'h0100, lat);
    check("fdone_lat", lat, 17);
    bus.flush = 1'b1;
    #1;
    check("fdone_done", bus.done, 1);
    check("fdone_hi", bus.result_hi, 16'h0001);
    @(negedge clk);
    bus.flush = 1'b0;
    check("fdone_idle", bus.busy, 0);
    check("fdone_hold_lo", bus.result_lo, 16'h0000);

    // Reset asserted in cycle 10 of a long operation clears outputs at once.
    bus.start = 1'b1; bus.op = DIV_EN; bus.opA = 16'd100; bus.opB = 16'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_lo", bus.result_lo, 0);
    check("rst_mid_hi", bus.result_hi, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b0, 16'h0003, 16'h0005, lat);
    check("post_rst_lat", lat, 17);
    check("post_rst_lo", bus.result_lo, 16'h000F);
    check("post_rst_hi", bus.result_hi, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
